aes_key_sched: RTL

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_key_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and helpers for the AES key schedule
// Purpose: FSM state type, rcon constants, GF(2^8) xtime and the Nk/Nr
//          derivation from the cipher key length.
// Ports:   none (package).
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEY_OUT = 2'd1,
        EXPAND  = 2'd2
    } ks_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
// Purpose: one byte substitution through the AES S-box.
// Ports:   byte_i - input byte
//          byte_o - substituted byte
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - streaming AES-128/192/256 key expansion, one word per cycle
// Purpose: accepts a cipher key and streams round-key words w[0..4*Nr+3]
//          with a valid/ready handshake.
// Optional: AES_KS_ABORT_EN adds key_abort to cancel a running expansion.
// Ports:   clk, rst            - clock, asynchronous active-high reset
//          key_in, key_valid   - cipher key (MSB-first) and its valid
//          key_ready           - high in IDLE, key may be accepted
//          rk_word, rk_idx     - current round-key word and its index
//          rk_last             - current word is the final one
//          rk_valid, rk_ready  - round-key word handshake
//          key_abort           - (AES_KS_ABORT_EN only) return to IDLE
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [31:0]         rk_word,
    output logic [5:0]          rk_idx,
    output logic                rk_last,
    output logic                rk_valid,
    input  logic                rk_ready
`ifdef AES_KS_ABORT_EN
   ,input  logic                key_abort
`endif
);

    localparam int NK       = nk_of(KEY_BITS);
    localparam int NR       = nr_of(KEY_BITS);
    localparam int LAST_IDX = 4 * NR + 3;

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_key_sched: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_e           state_q, state_d;
    // Window holds w[i .. i+NK-1]; the oldest word (top) is the one on rk_word.
    logic [KEY_BITS-1:0] win_q, win_d;
    logic [5:0]          idx_q, idx_d;
    // Phase of the current index modulo NK; equals (i+NK) mod NK for the
    // word being generated at the back of the window.
    logic [2:0]          cnt_q, cnt_d;
    logic [7:0]          rcon_q, rcon_d;

    logic                abort;
    logic                hs;
    logic [31:0]         old_w, prev_w, rot_w, sub_in, sub_out, temp_w, next_w;

`ifdef AES_KS_ABORT_EN
    assign abort = key_abort;
`else
    assign abort = 1'b0;
`endif

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = (state_q != IDLE);
    assign rk_word   = old_w;
    assign rk_idx    = idx_q;
    assign rk_last   = rk_valid && (idx_q == 6'(LAST_IDX));

    // Abort wins over a same-cycle handshake.
    assign hs = rk_valid && rk_ready && !abort;

    // Each handshake of w[i] generates w[i+NK] = w[i] ^ temp(w[i+NK-1]).
    assign old_w  = win_q[KEY_BITS-1 -: 32];
    assign prev_w = win_q[31:0];
    assign rot_w  = {prev_w[23:0], prev_w[31:24]};
    assign sub_in = (cnt_q == 3'd0) ? rot_w : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (sub_in[8*b +: 8]),
            .byte_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp_w = prev_w;
        if (cnt_q == 3'd0) begin
            temp_w = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && cnt_q == 3'd4) begin
            temp_w = sub_out;
        end
    end

    assign next_w = old_w ^ temp_w;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = KEY_OUT;
                    win_d   = key_in;
                    idx_d   = 6'd0;
                    cnt_d   = 3'd0;
                    rcon_d  = RCON_INIT;
                end
            end
            KEY_OUT, EXPAND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hs) begin
                    win_d = {win_q[KEY_BITS-33:0], next_w};
                    idx_d = idx_q + 6'd1;
                    cnt_d = (cnt_q == 3'(NK - 1)) ? 3'd0 : cnt_q + 3'd1;
                    if (cnt_q == 3'd0) begin
                        rcon_d = xtime(rcon_q);
                    end
                    if (state_q == KEY_OUT && idx_q == 6'(NK - 1)) begin
                        state_d = EXPAND;
                    end
                    if (state_q == EXPAND && idx_q == 6'(LAST_IDX)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            idx_q   <= 6'd0;
            cnt_q   <= 3'd0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
        end
    end

endmodule
